i2c_wb_arbiter: RTL and testbench

Two-requester arbiter and transaction sequencer in front of the 8-bit Wishbone slave port of the I2C master core. It lets the CPU-side I2C controller (requester 0) and an autonomous sensor-poll engine (requester 1) share one I2C master. Each granted request becomes one single-beat Wishbone register access, with round-robin fairness and an ack timeout. Sits between the requesters and `i2c_master_wbs_8`, in place of a direct controller-to-slave connection.

---
 rtl/i2c_arb_pkg.sv | 19 +
 rtl/i2c_arb_rr2.sv | 15 +
 rtl/i2c_wb_arbiter.sv | 141 ++++++++++++++
 tb/tb_i2c_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C Wishbone arbiter
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERR   = 2'd3
  } arb_state_e;

  localparam int I2C_ARB_TIMEOUT_DEF = 255;

  // Register map of the 8-bit I2C master Wishbone slave
  localparam logic [2:0] I2C_REG_STATUS   = 3'h0;
  localparam logic [2:0] I2C_REG_CMD      = 3'h2;
  localparam logic [2:0] I2C_REG_DATA     = 3'h4;
  localparam logic [2:0] I2C_REG_PRESCALE = 3'h6;

endpackage

// File: rtl/i2c_arb_rr2.sv
// rtl/i2c_arb_rr2.sv - combinational two-way round-robin pick
module i2c_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  // On a tie the requester that was not served last wins
  always_comb begin
    valid = |req;
    idx   = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/i2c_wb_arbiter.sv
// rtl/i2c_wb_arbiter.sv - two-requester arbiter and single-beat Wishbone sequencer
module i2c_wb_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int ADR_W   = 3,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = I2C_ARB_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_stb,
  input  logic             req0_we,
  input  logic [ADR_W-1:0] req0_adr,
  input  logic [DAT_W-1:0] req0_dat_w,
  output logic [DAT_W-1:0] req0_dat_r,
  output logic             req0_ack,
  output logic             req0_err,
  input  logic             req1_stb,
  input  logic             req1_we,
  input  logic [ADR_W-1:0] req1_adr,
  input  logic [DAT_W-1:0] req1_dat_w,
  output logic [DAT_W-1:0] req1_dat_r,
  output logic             req1_ack,
  output logic             req1_err,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic             wbm_we_o,
  output logic             wbm_stb_o,
  output logic             wbm_cyc_o,
  input  logic [DAT_W-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic [1:0]       grant,
  output logic             busy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_e state, state_nxt;
  logic       last;
  logic [7:0] cnt;
  logic [1:0] req_elig;
  logic       pick_valid, pick_idx;
  logic       owner, tmo_hit;
  logic       start, capture, issue_end, resp_cyc, err_cyc;

  // A requester whose completion pulse is showing still holds a stale stb
  assign req_elig = {req1_stb & ~(req1_ack | req1_err),
                     req0_stb & ~(req0_ack | req0_err)};
  assign owner    = grant[1];
  assign tmo_hit  = (cnt == CNT_LAST);
  assign busy     = (state != ST_IDLE);

  i2c_arb_rr2 u_rr2 (
    .req   (req_elig),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (wbm_ack_i)    state_nxt = ST_RESP;
        else if (tmo_hit) state_nxt = ST_ERR;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start     = (state == ST_IDLE) && pick_valid;
    capture   = (state == ST_ISSUE) && wbm_ack_i && !wbm_we_o;
    issue_end = (state == ST_ISSUE) && (wbm_ack_i || tmo_hit);
    resp_cyc  = (state == ST_RESP);
    err_cyc   = (state == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= 1'b1;
      cnt        <= 8'd0;
      grant      <= 2'b00;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_we_o   <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      req0_dat_r <= '0;
      req1_dat_r <= '0;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      req0_err <= 1'b0;
      req1_err <= 1'b0;
      if (start) begin
        grant     <= pick_idx ? 2'b10 : 2'b01;
        wbm_adr_o <= pick_idx ? req1_adr : req0_adr;
        wbm_dat_o <= pick_idx ? req1_dat_w : req0_dat_w;
        wbm_we_o  <= pick_idx ? req1_we : req0_we;
        wbm_stb_o <= 1'b1;
        wbm_cyc_o <= 1'b1;
        cnt       <= 8'd0;
      end
      if (state == ST_ISSUE) cnt <= cnt + 8'd1;
      if (issue_end) begin
        wbm_stb_o <= 1'b0;
        wbm_cyc_o <= 1'b0;
      end
      if (capture) begin
        if (owner) req1_dat_r <= wbm_dat_i;
        else       req0_dat_r <= wbm_dat_i;
      end
      if (resp_cyc) begin
        req0_ack <= ~owner;
        req1_ack <= owner;
      end
      if (err_cyc) begin
        req0_err <= ~owner;
        req1_err <= owner;
      end
      if (resp_cyc || err_cyc) begin
        last  <= owner;
        grant <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// tb/tb_i2c_wb_arbiter.sv - self-checking bench for i2c_wb_arbiter
module tb_i2c_wb_arbiter;
  import i2c_arb_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]      stb, we, ack, err;
  logic [1:0][2:0] adr;
  logic [1:0][7:0] dw, dr;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o, wbm_dat_i;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i, busy;
  logic [1:0] grant;

  int   n_assert = 0;
  int   n_fail = 0;
  int   ack_delay = 1;
  logic [7:0] slave_rdata = 8'h00;

  always #5 clk = ~clk;

  i2c_wb_arbiter #(.ADR_W(3), .DAT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_stb(stb[0]), .req0_we(we[0]), .req0_adr(adr[0]), .req0_dat_w(dw[0]),
    .req0_dat_r(dr[0]), .req0_ack(ack[0]), .req0_err(err[0]),
    .req1_stb(stb[1]), .req1_we(we[1]), .req1_adr(adr[1]), .req1_dat_w(dw[1]),
    .req1_dat_r(dr[1]), .req1_ack(ack[1]), .req1_err(err[1]),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_we_o(wbm_we_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .grant(grant), .busy(busy)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Slave: acks in the ack_delay-th cycle of cyc (0 = never) and logs what it accepted
  int s_cnt = 0;
  logic [11:0] seen[$];
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 8'h00;
    forever begin
      @(negedge clk);
      if (wbm_cyc_o) begin
        s_cnt++;
        wbm_dat_i = slave_rdata;
        if (ack_delay != 0 && s_cnt == ack_delay) begin
          wbm_ack_i = 1'b1;
          seen.push_back({wbm_we_o, wbm_adr_o, wbm_dat_o});
        end else wbm_ack_i = 1'b0;
      end else begin
        s_cnt = 0;
        wbm_ack_i = 1'b0;
      end
    end
  end

  // Transaction-timeline model: a grant at edge g with response length n keeps
  // cyc up for n cycles, reports at edge g+n+1, and frees arbitration after that.
  int edge_n = 0;
  int m_own, m_g, m_n, m_last, m_w;
  bit m_ok;
  logic [1:0] m_ack, m_err, m_elig;
  logic [2:0] m_adr;
  logic [7:0] m_dat;
  logic       m_we;
  logic [1:0][7:0] m_dr;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_own = -1; m_last = 1; m_ack = 2'b00; m_err = 2'b00;
      m_adr = 3'h0; m_dat = 8'h00; m_we = 1'b0; m_dr = '0;
    end else begin
      m_elig = stb & ~(m_ack | m_err);
      m_ack = 2'b00;
      m_err = 2'b00;
      if (m_own < 0) begin
        if (m_elig != 2'b00) begin
          m_w = (m_elig == 2'b11) ? 1 - m_last : (m_elig[1] ? 1 : 0);
          m_own = m_w; m_g = edge_n;
          m_adr = adr[m_w]; m_dat = dw[m_w]; m_we = we[m_w];
          m_ok = (ack_delay >= 1 && ack_delay <= TO);
          m_n = m_ok ? ack_delay : TO;
        end
      end else if (edge_n == m_g + m_n) begin
        if (m_ok && !m_we) m_dr[m_own] = wbm_dat_i;
      end else if (edge_n == m_g + m_n + 1) begin
        if (m_ok) m_ack[m_own] = 1'b1;
        else      m_err[m_own] = 1'b1;
        m_last = m_own;
        m_own = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("m_cyc",   wbm_cyc_o, (m_own >= 0 && edge_n < m_g + m_n));
      check("m_stb",   wbm_stb_o, (m_own >= 0 && edge_n < m_g + m_n));
      check("m_busy",  busy, (m_own >= 0));
      check("m_grant", grant, (m_own < 0) ? 2'b00 : (m_own == 1 ? 2'b10 : 2'b01));
      check("m_ack",   ack, m_ack);
      check("m_err",   err, m_err);
      check("m_adr",   wbm_adr_o, m_adr);
      check("m_dat",   wbm_dat_o, m_dat);
      check("m_we",    wbm_we_o, m_we);
      check("m_dr0",   dr[0], m_dr[0]);
      check("m_dr1",   dr[1], m_dr[1]);
    end
  end

  // Running event counters, read as deltas by the directed sequence
  int tot_cyc = 0;
  int tot_ack[2] = '{0, 0};
  int tot_err[2] = '{0, 0};
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] gq[$];
  always @(negedge clk) begin
    if (wbm_cyc_o) tot_cyc++;
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) tot_ack[i]++;
      if (err[i]) tot_err[i]++;
    end
    if (grant != 2'b00 && prev_grant == 2'b00) gq.push_back(grant);
    prev_grant = grant;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input int n, input logic w, input logic [2:0] a,
                        input logic [7:0] d, output int res);
    @(negedge clk);
    we[n] = w; adr[n] = a; dw[n] = d; stb[n] = 1'b1;
    res = 0;
    for (int t = 0; t < 60 && res == 0; t++) begin
      @(negedge clk);
      if (ack[n]) res = 1;
      else if (err[n]) res = 2;
    end
    stb[n] = 1'b0;
    if (res == 0) check("req_wait", 0, 1);
  endtask

  int r0, r1, c0, a0, a1, e0, e1, gs, ss, got;

  initial begin
    rst = 1'b1; stb = 2'b00; we = 2'b00; adr = '0; dw = '0;
    idle(2);
    rst = 1'b0;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_cyc", wbm_cyc_o, 1'b0);
    check("rst_dr0", dr[0], 8'h00);

    // Single read, slave acks in its 2nd cycle
    ack_delay = 2; slave_rdata = 8'hA5;
    c0 = tot_cyc; a0 = tot_ack[0]; a1 = tot_ack[1];
    do_req(0, 1'b0, I2C_REG_CMD, 8'h00, r0);
    idle(2);
    check("rd_res", r0, 1);
    check("rd_dat", dr[0], 8'hA5);
    check("rd_cyc_len", tot_cyc - c0, 2);
    check("rd_ack0", tot_ack[0] - a0, 1);
    check("rd_ack1", tot_ack[1] - a1, 0);

    // Tie right after reset: requester 0 first
    apply_reset();
    ack_delay = 1;
    gs = gq.size(); ss = seen.size();
    fork
      do_req(0, 1'b1, 3'h1, 8'h11, r0);
      do_req(1, 1'b1, 3'h1, 8'h22, r1);
    join
    idle(2);
    check("tie_nseen", seen.size() - ss, 2);
    check("tie_seen0", seen[ss], {1'b1, 3'h1, 8'h11});
    check("tie_seen1", seen[ss + 1], {1'b1, 3'h1, 8'h22});
    check("tie_g0", gq[gs], 2'b01);
    check("tie_g1", gq[gs + 1], 2'b10);

    // Both held continuously for six transactions
    ack_delay = 1; slave_rdata = 8'h3C;
    gs = gq.size();
    @(negedge clk);
    we = 2'b00; adr[0] = I2C_REG_DATA; adr[1] = I2C_REG_STATUS; stb = 2'b11;
    got = 0;
    for (int t = 0; t < 200 && got < 6; t++) begin
      @(negedge clk);
      if (ack[0]) got++;
      if (ack[1]) got++;
    end
    stb = 2'b00;
    idle(3);
    check("fair_count", got, 6);
    check("fair_ngrant", gq.size() - gs, 6);
    for (int i = 0; i < 6; i++)
      check("fair_seq", gq[gs + i], (i % 2 == 0) ? 2'b01 : 2'b10);
    check("fair_dr1", dr[1], 8'h3C);

    // Timeout: slave never acks
    ack_delay = 0; slave_rdata = 8'hEE;
    c0 = tot_cyc; a1 = tot_ack[1]; e1 = tot_err[1];
    do_req(1, 1'b0, I2C_REG_STATUS, 8'h00, r1);
    idle(2);
    check("to_res", r1, 2);
    check("to_cyc_len", tot_cyc - c0, TO);
    check("to_err1", tot_err[1] - e1, 1);
    check("to_ack1", tot_ack[1] - a1, 0);
    check("to_dr1", dr[1], 8'h3C);
    ack_delay = 3; slave_rdata = 8'h5A;
    do_req(1, 1'b0, I2C_REG_STATUS, 8'h00, r1);
    idle(2);
    check("after_to_res", r1, 1);
    check("after_to_dr1", dr[1], 8'h5A);

    // Ack exactly at the timeout count
    ack_delay = TO; slave_rdata = 8'h99;
    c0 = tot_cyc; a0 = tot_ack[0]; e0 = tot_err[0];
    do_req(0, 1'b0, I2C_REG_DATA, 8'h00, r0);
    idle(2);
    check("bnd_res", r0, 1);
    check("bnd_ack0", tot_ack[0] - a0, 1);
    check("bnd_err0", tot_err[0] - e0, 0);
    check("bnd_dr0", dr[0], 8'h99);
    check("bnd_cyc_len", tot_cyc - c0, TO);

    // Reset in the middle of ISSUE
    ack_delay = 0;
    a0 = tot_ack[0]; e0 = tot_err[0];
    @(negedge clk);
    we[0] = 1'b0; adr[0] = I2C_REG_PRESCALE; stb[0] = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && got == 0; t++) begin
      @(negedge clk);
      if (wbm_cyc_o) got = 1;
    end
    check("mid_cyc_seen", got, 1);
    @(negedge clk);
    rst = 1'b1; stb[0] = 1'b0;
    @(negedge clk);
    check("mid_cyc", wbm_cyc_o, 1'b0);
    check("mid_grant", grant, 2'b00);
    rst = 1'b0;
    idle(4);
    check("mid_ack0", tot_ack[0] - a0, 0);
    check("mid_err0", tot_err[0] - e0, 0);
    ack_delay = 1;
    gs = gq.size();
    fork
      do_req(0, 1'b1, I2C_REG_PRESCALE, 8'h77, r0);
      do_req(1, 1'b1, I2C_REG_PRESCALE, 8'h88, r1);
    join
    idle(2);
    check("mid_tie_g0", gq[gs], 2'b01);
    check("mid_tie_g1", gq[gs + 1], 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
